// File: rtl/game_pkg.sv
// Shared encodings and the K-run line-mask generator for the N x N board model.
package game_pkg;

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_X_WIN   = 2'd1,
    ST_O_WIN   = 2'd2,
    ST_DRAW    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_GAME_OVER = 2'd1,
    ERR_BAD_CELL  = 2'd2,
    ERR_OCCUPIED  = 2'd3
  } err_e;

  typedef struct packed {
    logic ok;
    logic err;
    err_e code;
  } mv_rsp_t;

  localparam int MAX_CELLS = 256;

  function automatic int num_lines(input int n, input int k);
    return 2 * n * (n - k + 1) + 2 * (n - k + 1) * (n - k + 1);
  endfunction

  // Lines ordered as rows, columns, diagonals, anti-diagonals; each scanned by start cell.
  function automatic logic [MAX_CELLS-1:0] line_mask(input int n, input int k, input int idx);
    logic [MAX_CELLS-1:0] m;
    int cnt;
    bit ok;
    m   = '0;
    cnt = 0;
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          case (d)
            0:       ok = (c <= n - k);
            1:       ok = (r <= n - k);
            2:       ok = (r <= n - k) && (c <= n - k);
            default: ok = (r <= n - k) && (c >= k - 1);
          endcase
          if (ok) begin
            if (cnt == idx) begin
              for (int i = 0; i < k; i++) begin
                case (d)
                  0:       m[r * n + c + i]       = 1'b1;
                  1:       m[(r + i) * n + c]     = 1'b1;
                  2:       m[(r + i) * n + c + i] = 1'b1;
                  default: m[(r + i) * n + c - i] = 1'b1;
                endcase
              end
            end
            cnt++;
          end
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/win_detect.sv
// Combinational K-in-a-row detector: flags a win and returns the union of all completed runs.
module win_detect
  import game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CELLS = N * N
) (
  input  logic [CELLS-1:0] i_board,
  output logic             o_win,
  output logic [CELLS-1:0] o_line
);

  localparam int NL = num_lines(N, K);

  logic [NL-1:0][CELLS-1:0] w_part;

  for (genvar g = 0; g < NL; g++) begin : g_line
    localparam logic [MAX_CELLS-1:0] LM = line_mask(N, K, g);
    localparam logic [CELLS-1:0]     LC = LM[CELLS-1:0];
    assign w_part[g] = (&(i_board | ~LC)) ? LC : '0;
  end

  always_comb begin
    o_line = '0;
    for (int i = 0; i < NL; i++) o_line = o_line | w_part[i];
  end

  assign o_win = |o_line;

endmodule

// File: rtl/game_model_nxn.sv
// N x N board model: edge-qualified move requests, validation, turn/count tracking, win/draw status.
module game_model_nxn
  import game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int CELLS = N * N,
  localparam int CW = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CELLS-1:0] C,
  input  logic             writeEn,
  output logic [CELLS-1:0] X,
  output logic [CELLS-1:0] O,
  output logic             turn,
  output logic [1:0]       game_state,
  output logic [CELLS-1:0] win_line,
  output logic [CW-1:0]    move_cnt,
  output logic             move_ok,
  output logic             move_err,
  output logic [1:0]       err_code
);

  logic [CELLS-1:0] r_x, r_o, r_wl;
  logic             r_turn, r_armed;
  logic [CW-1:0]    r_cnt;
  state_e           r_state;
  mv_rsp_t          r_rsp;

  logic             w_fire, w_onehot, w_accept, w_win;
  logic [CELLS-1:0] w_mover_nxt, w_wl;
  err_e             w_code;
  state_e           w_state_nxt;

  assign w_fire      = writeEn & r_armed;
  assign w_onehot    = (C != '0) && ((C & (C - 1'b1)) == '0);
  assign w_accept    = w_fire && (w_code == ERR_NONE);
  assign w_mover_nxt = (r_turn ? r_o : r_x) | C;

  // Only the mover can newly win, so one detector on its next-state board suffices.
  win_detect #(.N(N), .K(K)) u_win (
    .i_board (w_mover_nxt),
    .o_win   (w_win),
    .o_line  (w_wl)
  );

  always_comb begin
    w_code = ERR_NONE;
    if (r_state != ST_PLAYING)     w_code = ERR_GAME_OVER;
    else if (!w_onehot)            w_code = ERR_BAD_CELL;
    else if (|(C & (r_x | r_o)))   w_code = ERR_OCCUPIED;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (w_win)                   w_state_nxt = r_turn ? ST_O_WIN : ST_X_WIN;
      else if (&(r_x | r_o | C))   w_state_nxt = ST_DRAW;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) r_state <= ST_PLAYING;
    else                   r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_x     <= '0;
      r_o     <= '0;
      r_wl    <= '0;
      r_turn  <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_rsp   <= '{ok: 1'b0, err: 1'b0, code: ERR_NONE};
    end else begin
      r_rsp.ok  <= 1'b0;
      r_rsp.err <= 1'b0;
      if (w_fire)        r_armed <= 1'b0;
      else if (!writeEn) r_armed <= 1'b1;
      if (w_accept) begin
        if (r_turn) r_o <= w_mover_nxt;
        else        r_x <= w_mover_nxt;
        r_turn   <= ~r_turn;
        r_cnt    <= r_cnt + 1'b1;
        r_rsp.ok <= 1'b1;
        if (w_win) r_wl <= w_wl;
      end else if (w_fire) begin
        r_rsp.err  <= 1'b1;
        r_rsp.code <= w_code;
      end
    end
  end

  assign X          = r_x;
  assign O          = r_o;
  assign turn       = r_turn;
  assign game_state = r_state;
  assign win_line   = r_wl;
  assign move_cnt   = r_cnt;
  assign move_ok    = r_rsp.ok;
  assign move_err   = r_rsp.err;
  assign err_code   = r_rsp.code;

endmodule

// File: tb/tb_game_model_nxn.sv
// Bench for game_model_nxn: 3x3/K3 and 5x5/K4 instances against a geometric reference model.
module tb_game_model_nxn;

  logic clk, rst_n, clr, we;
  logic [8:0]  C3;
  logic [24:0] C5;

  logic [8:0]  X3, O3, WL3;
  logic        T3, OK3, ER3;
  logic [1:0]  ST3, EC3;
  logic [3:0]  CN3;
  logic [24:0] X5, O5, WL5;
  logic        T5, OK5, ER5;
  logic [1:0]  ST5, EC5;
  logic [4:0]  CN5;

  game_model_nxn #(.N(3), .K(3)) dut3 (
    .clk(clk), .reset_n(rst_n), .clear(clr), .C(C3), .writeEn(we),
    .X(X3), .O(O3), .turn(T3), .game_state(ST3), .win_line(WL3), .move_cnt(CN3),
    .move_ok(OK3), .move_err(ER3), .err_code(EC3));

  game_model_nxn #(.N(5), .K(4)) dut5 (
    .clk(clk), .reset_n(rst_n), .clear(clr), .C(C5), .writeEn(we),
    .X(X5), .O(O5), .turn(T5), .game_state(ST5), .win_line(WL5), .move_cnt(CN5),
    .move_ok(OK5), .move_err(ER5), .err_code(EC5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] x, o, wl;
    logic        turn;
    logic [1:0]  st;
    logic [7:0]  cnt;
    logic        ok, err;
    logic [1:0]  code;
    logic        armed;
  } mdl_t;

  mdl_t m3, m5;
  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scan every cell as a run start in each of the four directions.
  function automatic logic [24:0] win_mask(input logic [24:0] b, input int n, input int k);
    logic [24:0] m;
    int dr, dc, er, ec;
    bit all;
    m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
          er = r + dr * (k - 1);
          ec = c + dc * (k - 1);
          if (er < n && ec >= 0 && ec < n) begin
            all = 1;
            for (int i = 0; i < k; i++) if (!b[(r + dr * i) * n + c + dc * i]) all = 0;
            if (all) for (int i = 0; i < k; i++) m[(r + dr * i) * n + c + dc * i] = 1'b1;
          end
        end
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int n, input int k,
                                input bit rst, input bit cl, input bit w, input logic [24:0] c);
    mdl_t r;
    logic [31:0] full;
    logic [24:0] mb, wm;
    r = m;
    full = (32'd1 << (n * n)) - 1;
    r.ok = 0;
    r.err = 0;
    if (!rst || cl) begin
      r = '0;
      r.armed = 1;
      return r;
    end
    if (w && m.armed) begin
      r.armed = 0;
      if (m.st != 0)                begin r.err = 1; r.code = 1; end
      else if ($countones(c) != 1)  begin r.err = 1; r.code = 2; end
      else if ((c & (m.x | m.o)) != 0) begin r.err = 1; r.code = 3; end
      else begin
        if (m.turn) r.o = m.o | c; else r.x = m.x | c;
        mb = m.turn ? r.o : r.x;
        r.turn = ~m.turn;
        r.cnt = m.cnt + 1;
        r.ok = 1;
        wm = win_mask(mb, n, k);
        if (wm != 0) begin
          r.st = m.turn ? 2'd2 : 2'd1;
          r.wl = wm;
        end else if ({7'd0, r.x | r.o} == full) r.st = 2'd3;
      end
    end else if (!w) r.armed = 1;
    return r;
  endfunction

  always @(posedge clk) begin
    m3 = step(m3, 3, 3, rst_n, clr, we, {16'd0, C3});
    m5 = step(m5, 5, 4, rst_n, clr, we, C5);
  end

  always @(negedge clk) if (chk_en) begin
    cmp("x3", 32'(X3), 32'(m3.x[8:0]));
    cmp("o3", 32'(O3), 32'(m3.o[8:0]));
    cmp("turn3", 32'(T3), 32'(m3.turn));
    cmp("state3", 32'(ST3), 32'(m3.st));
    cmp("wl3", 32'(WL3), 32'(m3.wl[8:0]));
    cmp("cnt3", 32'(CN3), 32'(m3.cnt));
    cmp("ok3", 32'(OK3), 32'(m3.ok));
    cmp("err3", 32'(ER3), 32'(m3.err));
    cmp("code3", 32'(EC3), 32'(m3.code));
    cmp("x5", 32'(X5), 32'(m5.x));
    cmp("o5", 32'(O5), 32'(m5.o));
    cmp("turn5", 32'(T5), 32'(m5.turn));
    cmp("state5", 32'(ST5), 32'(m5.st));
    cmp("wl5", 32'(WL5), 32'(m5.wl));
    cmp("cnt5", 32'(CN5), 32'(m5.cnt));
    cmp("ok5", 32'(OK5), 32'(m5.ok));
    cmp("err5", 32'(ER5), 32'(m5.err));
    cmp("code5", 32'(EC5), 32'(m5.code));
  end

  logic lok, lerr;

  task automatic req3(input logic [8:0] c);
    C3 = c; we = 1;
    @(negedge clk);
    lok = OK3; lerr = ER3;
    we = 0;
    @(negedge clk);
  endtask

  task automatic req5(input logic [24:0] c);
    C5 = c; we = 1;
    @(negedge clk);
    lok = OK5; lerr = ER5;
    we = 0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1;
    @(negedge clk);
    clr = 0;
    @(negedge clk);
  endtask

  task automatic play3(input int cells[9], input int cnt);
    for (int i = 0; i < cnt; i++) req3(9'd1 << cells[i]);
  endtask

  initial begin
    int okc;
    int seq_row[9]  = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_lwin[9] = '{0, 1, 2, 3, 4, 5, 7, 6, 8};
    rst_n = 0; clr = 0; we = 0; C3 = '0; C5 = '0;
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    cmp("rst_x", 32'(X3), 32'h0);
    cmp("rst_o", 32'(O3), 32'h0);
    cmp("rst_turn", 32'(T3), 32'h0);
    cmp("rst_state", 32'(ST3), 32'h0);

    // Held writeEn gives a single request
    okc = 0;
    C3 = 9'h001; we = 1;
    repeat (5) begin @(negedge clk); okc += OK3; end
    we = 0;
    @(negedge clk);
    cmp("hold_okcnt", 32'(okc), 32'd1);
    cmp("hold_x", 32'(X3), 32'h001);
    cmp("hold_cnt", 32'(CN3), 32'd1);

    req3(9'h001);
    cmp("occ_err", 32'(lerr), 32'd1);
    cmp("occ_code", 32'(EC3), 32'd3);
    cmp("occ_turn", 32'(T3), 32'd1);
    req3(9'h003);
    cmp("multi_code", 32'(EC3), 32'd2);
    req3(9'h000);
    cmp("zero_code", 32'(EC3), 32'd2);
    cmp("zero_err", 32'(lerr), 32'd1);

    do_clear();
    cmp("clr_code", 32'(EC3), 32'd0);
    play3(seq_row, 4);
    cmp("row_pre", 32'(ST3), 32'd0);
    req3(9'd1 << seq_row[4]);
    cmp("row_state", 32'(ST3), 32'd1);
    cmp("row_wl", 32'(WL3), 32'h007);
    req3(9'h020);
    cmp("over_code", 32'(EC3), 32'd1);
    cmp("over_x", 32'(X3), 32'h007);

    do_clear();
    play3(seq_draw, 9);
    cmp("draw_state", 32'(ST3), 32'd3);
    cmp("draw_cnt", 32'(CN3), 32'd9);
    cmp("draw_wl", 32'(WL3), 32'h0);

    do_clear();
    play3(seq_lwin, 9);
    cmp("lastwin_state", 32'(ST3), 32'd1);
    cmp("lastwin_wl", 32'(WL3), 32'h111);
    cmp("lastwin_cnt", 32'(CN3), 32'd9);

    // 5x5, K=4 anti-diagonal
    do_clear();
    C3 = '0;
    req5(25'd1 << 4);  req5(25'd1 << 0);
    req5(25'd1 << 8);  req5(25'd1 << 1);
    req5(25'd1 << 12); req5(25'd1 << 24);
    cmp("anti_pre", 32'(ST5), 32'd0);
    req5(25'd1 << 16);
    cmp("anti_state", 32'(ST5), 32'd1);
    cmp("anti_wl", 32'(WL5), 32'h0011110);
    C5 = '0;

    do_clear();
    req3(9'h001); req3(9'h010);
    clr = 1; we = 1; C3 = 9'h100;
    @(negedge clk);
    cmp("clrwe_x", 32'(X3), 32'h0);
    cmp("clrwe_o", 32'(O3), 32'h0);
    cmp("clrwe_ok", 32'(OK3), 32'd0);
    cmp("clrwe_turn", 32'(T3), 32'd0);
    clr = 0; we = 0;
    @(negedge clk);
    req3(9'h001);
    rst_n = 0; we = 1; C3 = 9'h002;
    @(negedge clk);
    cmp("rstwe_x", 32'(X3), 32'h0);
    cmp("rstwe_ok", 32'(OK3), 32'd0);
    cmp("rstwe_turn", 32'(T3), 32'd0);
    rst_n = 1; we = 0;
    @(negedge clk);

    repeat (4000) begin
      @(negedge clk);
      we  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 2);
      rst_n = !($urandom_range(0, 199) == 0);
      C3 = ($urandom_range(0, 9) < 8) ? (9'd1 << $urandom_range(0, 8)) : 9'($urandom);
      C5 = ($urandom_range(0, 9) < 8) ? (25'd1 << $urandom_range(0, 24)) : 25'($urandom);
    end
    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
